// File: rtl/gemm_pkg.sv
// ============================================================================
//  gemm_pkg : shared opcodes, instruction field layout and sequencer states
//  Rev 1.0
// ============================================================================
`default_nettype none

package gemm_pkg;

   localparam int OPC_LSB       = 0;
   localparam int OPC_W         = 3;
   localparam int POP_PREV_BIT  = 3;
   localparam int POP_NEXT_BIT  = 4;
   localparam int PUSH_PREV_BIT = 5;
   localparam int PUSH_NEXT_BIT = 6;
   localparam int UOP_BGN_LSB   = 8;
   localparam int UOP_BGN_W     = 13;
   localparam int UOP_END_LSB   = 21;
   localparam int UOP_END_W     = 14;
   localparam int ITER_OUT_LSB  = 35;
   localparam int ITER_IN_LSB   = 49;
   localparam int ITER_W        = 14;

   localparam logic [2:0] OPC_GEMM_DEF   = 3'd2;
   localparam logic [2:0] OPC_FINISH_DEF = 3'd3;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_POP  = 3'd1;
   localparam logic [2:0] ST_EXEC = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_PUSH = 3'd4;

   typedef struct packed {
      logic [ITER_W-1:0]    iter_in;
      logic [ITER_W-1:0]    iter_out;
      logic [UOP_END_W-1:0] uop_end;
      logic [UOP_BGN_W-1:0] uop_bgn;
      logic                 push_next;
      logic                 push_prev;
      logic                 pop_next;
      logic                 pop_prev;
      logic [OPC_W-1:0]     opcode;
   } insn_fields_t;

endpackage

`default_nettype wire

// File: rtl/dep_token_cnt.sv
// ============================================================================
//  dep_token_cnt : saturating dependency-token counter with valid/ready input
//  Rev 1.0
// ============================================================================
`default_nettype none

module dep_token_cnt #(
   parameter int W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_valid,
   output logic o_ready,
   input  logic i_pop,
   output logic o_nonzero
);

   logic [W-1:0] r_cnt;
   logic         w_full;
   logic         w_inc;

   // Back-pressure at full count so a token is never dropped.
   assign w_full    = &r_cnt;
   assign o_ready   = ~w_full;
   assign w_inc     = i_valid & ~w_full;
   assign o_nonzero = |r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_inc && !i_pop) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (!w_inc && i_pop) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/gemm_insn_ctrl.sv
// ============================================================================
//  gemm_insn_ctrl : instruction sequencer with dependency tokens for gemm core
//  Rev 1.0
// ============================================================================
`default_nettype none

module gemm_insn_ctrl
   import gemm_pkg::*;
#(
   parameter int INS_WIDTH = 128,
   parameter int TOK_WIDTH = 4,
   parameter int OP_GEMM   = 2,
   parameter int OP_FINISH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 insn_valid,
   output logic                 insn_ready,
   input  logic [INS_WIDTH-1:0] insn_data,
   input  logic                 l2g_dep_valid,
   output logic                 l2g_dep_ready,
   input  logic                 s2g_dep_valid,
   output logic                 s2g_dep_ready,
   output logic                 g2l_dep_valid,
   input  logic                 g2l_dep_ready,
   output logic                 g2s_dep_valid,
   input  logic                 g2s_dep_ready,
   output logic [INS_WIDTH-1:0] gemm_insn,
   output logic                 gemm_start,
   input  logic                 gemm_done,
   output logic                 busy,
   output logic                 finish,
   output logic                 err_opcode
);

   localparam logic [2:0] c_op_gemm   = 3'(OP_GEMM);
   localparam logic [2:0] c_op_finish = 3'(OP_FINISH);

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;
   logic [INS_WIDTH-1:0] r_insn;
   logic                 r_g2l_pend;
   logic                 r_g2s_pend;
   logic                 r_finish;
   logic                 r_err;
   insn_fields_t         w_f;
   logic                 w_prev_nz;
   logic                 w_next_nz;
   logic                 w_is_gemm;
   logic                 w_is_finish;
   logic                 w_degenerate;
   logic                 w_deps_ok;
   logic                 w_pop_go;
   logic                 w_run_core;
   logic                 w_enter_push;
   logic                 w_push_clear;

   // Fields always come from the latched word, never the live input bus.
   assign w_f.opcode    = r_insn[OPC_LSB +: OPC_W];
   assign w_f.pop_prev  = r_insn[POP_PREV_BIT];
   assign w_f.pop_next  = r_insn[POP_NEXT_BIT];
   assign w_f.push_prev = r_insn[PUSH_PREV_BIT];
   assign w_f.push_next = r_insn[PUSH_NEXT_BIT];
   assign w_f.uop_bgn   = r_insn[UOP_BGN_LSB +: UOP_BGN_W];
   assign w_f.uop_end   = r_insn[UOP_END_LSB +: UOP_END_W];
   assign w_f.iter_out  = r_insn[ITER_OUT_LSB +: ITER_W];
   assign w_f.iter_in   = r_insn[ITER_IN_LSB +: ITER_W];

   assign w_is_gemm    = (w_f.opcode == c_op_gemm);
   assign w_is_finish  = (w_f.opcode == c_op_finish);
   assign w_degenerate = (w_f.iter_out == '0) || (w_f.iter_in == '0) ||
                         ({1'b0, w_f.uop_bgn} >= w_f.uop_end);
   assign w_deps_ok    = (!w_f.pop_prev || w_prev_nz) && (!w_f.pop_next || w_next_nz);
   assign w_pop_go     = (r_state == ST_POP) && w_deps_ok;
   assign w_run_core   = w_is_gemm && !w_degenerate;
   assign w_enter_push = (w_pop_go && !w_run_core) || ((r_state == ST_WAIT) && gemm_done);
   assign w_push_clear = (!r_g2l_pend || g2l_dep_ready) && (!r_g2s_pend || g2s_dep_ready);

   dep_token_cnt #(.W(TOK_WIDTH)) u_prev_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (l2g_dep_valid),
      .o_ready   (l2g_dep_ready),
      .i_pop     (w_pop_go && w_f.pop_prev),
      .o_nonzero (w_prev_nz)
   );

   dep_token_cnt #(.W(TOK_WIDTH)) u_next_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (s2g_dep_valid),
      .o_ready   (s2g_dep_ready),
      .i_pop     (w_pop_go && w_f.pop_next),
      .o_nonzero (w_next_nz)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (insn_valid) w_state_nxt = ST_POP;
         ST_POP:  if (w_deps_ok) w_state_nxt = w_run_core ? ST_EXEC : ST_PUSH;
         ST_EXEC: w_state_nxt = ST_WAIT;
         ST_WAIT: if (gemm_done) w_state_nxt = ST_PUSH;
         ST_PUSH: if (w_push_clear) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_insn     <= '0;
         r_g2l_pend <= 1'b0;
         r_g2s_pend <= 1'b0;
         r_finish   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && insn_valid) begin
            r_insn <= insn_data;
         end
         // Each push request drops on its own handshake, independently.
         if (w_enter_push) begin
            r_g2l_pend <= w_f.push_prev;
            r_g2s_pend <= w_f.push_next;
         end else if (r_state == ST_PUSH) begin
            r_g2l_pend <= r_g2l_pend && !g2l_dep_ready;
            r_g2s_pend <= r_g2s_pend && !g2s_dep_ready;
         end
         r_finish <= w_pop_go && w_is_finish;
         if (w_pop_go && !w_is_gemm && !w_is_finish) begin
            r_err <= 1'b1;
         end
      end
   end

   assign insn_ready    = (r_state == ST_IDLE);
   assign busy          = (r_state != ST_IDLE);
   assign gemm_start    = (r_state == ST_EXEC);
   assign gemm_insn     = r_insn;
   assign g2l_dep_valid = r_g2l_pend;
   assign g2s_dep_valid = r_g2s_pend;
   assign finish        = r_finish;
   assign err_opcode    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gemm_insn_ctrl.sv
// ============================================================================
//  tb_gemm_insn_ctrl : directed plus randomized bench with reference model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_gemm_insn_ctrl;

   localparam int MAXT = 15;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         insn_valid = 1'b0;
   logic [127:0] insn_data = '0;
   logic         l2g_dep_valid = 1'b0;
   logic         s2g_dep_valid = 1'b0;
   logic         g2l_dep_ready = 1'b1;
   logic         g2s_dep_ready = 1'b1;
   logic         gemm_done = 1'b0;
   logic         insn_ready, l2g_dep_ready, s2g_dep_ready;
   logic         g2l_dep_valid, g2s_dep_valid;
   logic [127:0] gemm_insn;
   logic         gemm_start, busy, finish, err_opcode;

   always #5 clk = ~clk;

   gemm_insn_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .insn_valid    (insn_valid),
      .insn_ready    (insn_ready),
      .insn_data     (insn_data),
      .l2g_dep_valid (l2g_dep_valid),
      .l2g_dep_ready (l2g_dep_ready),
      .s2g_dep_valid (s2g_dep_valid),
      .s2g_dep_ready (s2g_dep_ready),
      .g2l_dep_valid (g2l_dep_valid),
      .g2l_dep_ready (g2l_dep_ready),
      .g2s_dep_valid (g2s_dep_valid),
      .g2s_dep_ready (g2s_dep_ready),
      .gemm_insn     (gemm_insn),
      .gemm_start    (gemm_start),
      .gemm_done     (gemm_done),
      .busy          (busy),
      .finish        (finish),
      .err_opcode    (err_opcode)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: instruction phase 0=idle 1=awaiting tokens 2=start 3=core busy 4=pushing
   int           m_phase = 0;
   int           m_prev = 0;
   int           m_next = 0;
   logic [127:0] m_ins = '0;
   bit           m_gp = 0, m_sp = 0, m_fin = 0, m_err = 0;
   bit           chk_en = 0;

   always @(posedge clk) begin : model
      int  inc_p, inc_n, dec_p, dec_n, opc;
      bit  run;
      cyc++;
      if (!rst) begin
         m_phase = 0; m_prev = 0; m_next = 0; m_ins = '0;
         m_gp = 0; m_sp = 0; m_fin = 0; m_err = 0; chk_en = 1;
      end else begin
         inc_p = (l2g_dep_valid && m_prev < MAXT) ? 1 : 0;
         inc_n = (s2g_dep_valid && m_next < MAXT) ? 1 : 0;
         dec_p = 0; dec_n = 0; m_fin = 0;
         case (m_phase)
            0: if (insn_valid) begin m_ins = insn_data; m_phase = 1; end
            1: if ((!m_ins[3] || m_prev > 0) && (!m_ins[4] || m_next > 0)) begin
                  dec_p = int'(m_ins[3]); dec_n = int'(m_ins[4]);
                  opc = int'(m_ins[2:0]);
                  run = (opc == 2) && (m_ins[48:35] != 0) && (m_ins[62:49] != 0) &&
                        (m_ins[20:8] < m_ins[34:21]);
                  if (run) m_phase = 2;
                  else begin
                     m_phase = 4; m_gp = m_ins[5]; m_sp = m_ins[6];
                     m_fin = (opc == 3);
                     if (opc != 2 && opc != 3) m_err = 1;
                  end
               end
            2: m_phase = 3;
            3: if (gemm_done) begin m_phase = 4; m_gp = m_ins[5]; m_sp = m_ins[6]; end
            default: begin
               if (g2l_dep_ready) m_gp = 0;
               if (g2s_dep_ready) m_sp = 0;
               if (!m_gp && !m_sp) m_phase = 0;
            end
         endcase
         m_prev = m_prev + inc_p - dec_p;
         m_next = m_next + inc_n - dec_n;
      end
   end

   int n_start = 0, t_start = -1, n_fin = 0, n_g2l = 0, n_g2s = 0, n_l2g_hs = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("insn_ready", insn_ready, m_phase == 0);
         chk("busy", busy, m_phase != 0);
         chk("gemm_start", gemm_start, m_phase == 2);
         chk("gemm_insn", gemm_insn, m_ins);
         chk("l2g_ready", l2g_dep_ready, m_prev < MAXT);
         chk("s2g_ready", s2g_dep_ready, m_next < MAXT);
         chk("g2l_valid", g2l_dep_valid, m_gp);
         chk("g2s_valid", g2s_dep_valid, m_sp);
         chk("finish", finish, m_fin);
         chk("err_opcode", err_opcode, m_err);
      end
      if (gemm_start) begin n_start++; t_start = cyc; end
      if (finish) n_fin++;
      if (g2l_dep_valid) n_g2l++;
      if (g2s_dep_valid) n_g2s++;
      if (l2g_dep_valid && l2g_dep_ready) n_l2g_hs++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic logic [127:0] mk(input int opc, input bit pp, input bit pn, input bit qp,
                                       input bit qn, input int ub, input int ue, input int io,
                                       input int ii);
      logic [127:0] w;
      w = '0;
      w[2:0] = opc[2:0]; w[3] = pp; w[4] = pn; w[5] = qp; w[6] = qn;
      w[20:8] = ub[12:0]; w[34:21] = ue[13:0]; w[48:35] = io[13:0]; w[62:49] = ii[13:0];
      return w;
   endfunction

   task automatic wait_idle();
      int k = 0;
      while (insn_ready !== 1'b1 && k < 200) begin step(); k++; end
      if (k >= 200) chk("wait_idle_timeout", insn_ready, 1);
   endtask

   task automatic issue(input logic [127:0] w, output int t);
      wait_idle();
      insn_valid = 1'b1; insn_data = w; t = cyc;
      step();
      insn_valid = 1'b0;
   endtask

   initial begin
      int t, tt;
      logic [127:0] w;
      step(3);
      rst = 1'b1;
      step();
      chk("rst_insn_ready", insn_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_gemm_insn", gemm_insn, 0);
      chk("rst_l2g_ready", l2g_dep_ready, 1);

      // Plain GEMM: start two cycles after accept, ready again after done+2
      n_start = 0; n_g2l = 0; n_g2s = 0;
      issue(mk(2, 0, 0, 0, 0, 0, 2, 1, 1), t);
      while (cyc < t + 6) step();
      gemm_done = 1'b1; step(); gemm_done = 1'b0;
      step();
      chk("t1_ready_by_c8", insn_ready, 1);
      chk("t1_start_cycle", t_start - t, 2);
      chk("t1_start_count", n_start, 1);
      chk("t1_no_tokens", n_g2l + n_g2s, 0);

      // Pop stalls until a load token arrives
      n_start = 0;
      issue(mk(2, 1, 0, 0, 0, 0, 1, 1, 1), t);
      step(5);
      chk("t2_busy_stalled", busy, 1);
      chk("t2_no_start", n_start, 0);
      l2g_dep_valid = 1'b1; tt = cyc; step(); l2g_dep_valid = 1'b0;
      step(2);
      chk("t2_start_after_tok", t_start - tt, 2);
      gemm_done = 1'b1; step(); gemm_done = 1'b0;
      wait_idle();
      chk("t2_prev_cnt_zero", dut.u_prev_cnt.r_cnt, 0);

      // Independent push handshakes
      g2l_dep_ready = 1'b0; g2s_dep_ready = 1'b1; n_g2l = 0; n_g2s = 0;
      issue(mk(2, 0, 0, 1, 1, 0, 1, 0, 1), t);
      while (cyc < t + 5) step();
      chk("t3_busy_push", busy, 1);
      g2l_dep_ready = 1'b1; step();
      chk("t3_idle_after_hs", insn_ready, 1);
      chk("t3_g2l_cycles", n_g2l, 4);
      chk("t3_g2s_cycles", n_g2s, 1);

      // Token counter saturation
      n_l2g_hs = 0; l2g_dep_valid = 1'b1;
      step(16);
      chk("t4_accepted", n_l2g_hs, 15);
      chk("t4_ready_full", l2g_dep_ready, 0);
      issue(mk(2, 1, 0, 0, 0, 0, 1, 0, 1), t);
      while (cyc < t + 2) step();
      chk("t4_cnt_popped", dut.u_prev_cnt.r_cnt, 14);
      step();
      chk("t4_cnt_refilled", dut.u_prev_cnt.r_cnt, 15);
      l2g_dep_valid = 1'b0;

      // Degenerate GEMM, FINISH, bad opcode
      n_start = 0; n_fin = 0;
      issue(mk(2, 0, 0, 0, 0, 0, 3, 0, 2), t);
      wait_idle();
      chk("t5_no_start", n_start, 0);
      issue(mk(3, 0, 0, 0, 0, 0, 0, 0, 0), t);
      wait_idle(); step();
      chk("t5_finish_once", n_fin, 1);
      issue(mk(5, 0, 0, 0, 0, 0, 0, 0, 0), t);
      wait_idle(); step(5);
      chk("t5_err_sticky", err_opcode, 1);

      // Reset while waiting for the core
      issue(mk(2, 0, 0, 1, 1, 0, 1, 1, 1), t);
      while (cyc < t + 4) step();
      rst = 1'b0; step(); rst = 1'b1;
      chk("t6_busy", busy, 0);
      chk("t6_err_cleared", err_opcode, 0);
      chk("t6_ready", insn_ready, 1);
      chk("t6_prev_cnt", dut.u_prev_cnt.r_cnt, 0);
      gemm_done = 1'b1; step(); gemm_done = 1'b0; step();
      chk("t6_done_ignored", busy, 0);
      chk("t6_no_push", g2l_dep_valid | g2s_dep_valid, 0);

      // Randomized traffic
      for (int i = 0; i < 2500; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 5))
            0, 1, 2: w[2:0] = 3'd2;
            3:       w[2:0] = 3'd3;
            default: w[2:0] = 3'($urandom_range(0, 7));
         endcase
         w[20:8]  = 13'($urandom_range(0, 3));
         w[34:21] = 14'($urandom_range(0, 3));
         w[48:35] = 14'($urandom_range(0, 2));
         w[62:49] = 14'($urandom_range(0, 2));
         insn_data     = w;
         insn_valid    = 1'($urandom_range(0, 1));
         l2g_dep_valid = 1'($urandom_range(0, 1));
         s2g_dep_valid = 1'($urandom_range(0, 1));
         g2l_dep_ready = ($urandom_range(0, 9) < 6);
         g2s_dep_ready = ($urandom_range(0, 9) < 6);
         gemm_done     = ($urandom_range(0, 3) == 0);
         rst           = ($urandom_range(0, 299) != 0);
         step();
      end
      rst = 1'b1; insn_valid = 1'b0; gemm_done = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
